fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the instruction-buffer entry count; legal values are 2 and 4.
REQ-003 SHALL have a single clock and an asynchronous, active-high reset: clk input, 1 bit, rising-edge clock; reset input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have imem_req output, 1 bit: fetch request to instruction memory.
REQ-005 SHALL have imem_addr output, 32 bits: fetch address, equal to the current PC.
REQ-006 SHALL have imem_gnt input, 1 bit: memory accepts the request this cycle.
REQ-007 SHALL have imem_rvalid input, 1 bit, and imem_rdata input, 32 bits: response valid and response word.
REQ-008 SHALL have redirect input, 1 bit, and redirect_pc input, 32 bits: branch/jump target from execute (PCSrc path).
REQ-009 SHALL have instr_valid output, 1 bit; instr output, 32 bits; instr_pc output, 32 bits: buffer head presented to decode.
REQ-010 SHALL have op output, 7 bits: instr[6:0], driving the main decoder opcode input.
REQ-011 SHALL have instr_ready input, 1 bit: decode consumes the head this cycle.
REQ-012 SHALL have misalign output, 1 bit: misaligned redirect detected.

Function
REQ-013 SHALL implement FSM states FETCH, WAIT and DRAIN, with at most one outstanding memory request.
REQ-014 In FETCH, imem_req SHALL be high iff (occupancy + outstanding) < BUF_DEPTH, redirect is low, and misalign is low.
REQ-015 On imem_req && imem_gnt, the block SHALL latch imem_addr as the tag, set PC <= PC + 4 (wrapping modulo 2^32, 0xFFFF_FFFC -> 0), and go to WAIT.
REQ-016 In WAIT, on imem_rvalid, the block SHALL push {tag, imem_rdata} into the buffer and return to FETCH; the next request is issued no earlier than the following cycle.
REQ-017 instr_valid SHALL equal buffer-not-empty; instr, instr_pc and op SHALL reflect the head entry.
REQ-018 A pop SHALL occur on instr_valid && instr_ready.
REQ-019 There SHALL be no bypass: a pushed word is visible one cycle after the imem_rvalid cycle (latency: grant at N, rvalid at N+k, instr_valid at N+k+1).
REQ-020 Push and pop in the same cycle SHALL both take effect; a push into a full buffer is impossible by REQ-014.
REQ-021 Redirect SHALL have priority over push, pop and request: the buffer is flushed (instr_valid low next cycle) and PC <= redirect_pc.
REQ-022 On redirect in WAIT without imem_rvalid, the FSM SHALL go to DRAIN; DRAIN discards the next imem_rvalid and then returns to FETCH.
REQ-023 On redirect in WAIT with imem_rvalid in the same cycle, the response SHALL be discarded and the FSM goes to FETCH.
REQ-024 On redirect in DRAIN, the FSM SHALL stay in DRAIN with PC updated.
REQ-025 imem_addr SHALL remain stable while imem_req is high and imem_gnt is low.

Reset
REQ-026 While reset is high: PC = RESET_PC; state = FETCH; buffer empty with all storage zero; outstanding = 0; imem_req = 0; instr_valid = 0; instr = 0; instr_pc = 0; op = 0; misalign = 0.
REQ-027 A response arriving after reset mid-WAIT SHALL be ignored.
REQ-028 The first request SHALL be issued in the first cycle after reset deasserts.

Configuration
REQ-029 The macro FETCH_MISALIGN_CHK_EN SHALL control misaligned-redirect handling.
REQ-030 With FETCH_MISALIGN_CHK_EN defined: redirect with redirect_pc[1:0] != 0 sets misalign (sticky) and suppresses requests; only reset or a later aligned redirect clears it.
REQ-031 Without FETCH_MISALIGN_CHK_EN: redirect_pc[1:0] SHALL be forced to 00 and misalign tied to 0.

Structure
REQ-032 Package fetch_pkg SHALL hold fetch_state_t (FETCH/WAIT/DRAIN), the fetch_entry_t struct {pc[31:0], instr[31:0]}, PC_STEP = 4 and OPCODE_W = 7.
REQ-033 The buffer SHALL be a separate sub-module, fetch_fifo, parameterised by depth with push/pop/flush ports.

Verification
REQ-034 Reset release with imem_gnt=1 and rvalid one cycle after each grant -> imem_addr sequence 0x0, 0x4, 0x8; instr_pc follows the same values; op = imem_rdata[6:0] (e.g. 0x00000003 -> op 7'b0000011).
REQ-035 instr_ready=0 with BUF_DEPTH=2 -> exactly two grants, imem_req then low; one pop -> exactly one new request.
REQ-036 Redirect to 0x100 during WAIT, rvalid the next cycle carrying 0xDEADBEEF -> word discarded, next imem_addr = 0x100, instr_valid low until the 0x100 response.
REQ-037 PC at 0xFFFF_FFFC granted -> next imem_addr = 0x0000_0000.
REQ-038 Reset asserted mid-WAIT, then a stray rvalid after release -> instr_valid stays 0; imem_addr = RESET_PC.
REQ-039 With FETCH_MISALIGN_CHK_EN defined, redirect to 0x102 -> misalign = 1, imem_req = 0; then redirect to 0x200 -> misalign = 0 and fetch resumes at 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// fetch_state_t, fetch_entry_t and fetch constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam int          OPCODE_W = 7;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode.
// Power-of-two depth FIFO with push, pop and flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [63:0]                data_i,
    output logic [63:0]                head_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with buffered decode handoff.
// FETCH_MISALIGN_CHK_EN enables sticky misaligned-redirect detection.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [31:0]         instr_pc,
    output logic [OPCODE_W-1:0] op,
    input  logic                instr_ready,
    output logic                misalign
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tag_q, tag_d;
    logic          mis_q, mis_d;
    logic [31:0]   tgt;
    logic          mis_bad;
    logic          push, pop, empty;
    logic [CW-1:0] occ;
    fetch_entry_t  push_e, head_e;

`ifdef FETCH_MISALIGN_CHK_EN
    assign tgt     = redirect_pc;
    assign mis_bad = |redirect_pc[1:0];
`else
    assign tgt     = redirect_pc & ~32'h3;
    assign mis_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tag_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tag_d    = tag_q;
        mis_d    = mis_q;
        imem_req = 1'b0;
        push     = 1'b0;
        if (redirect) begin
            pc_d  = tgt;
            mis_d = mis_bad;
        end
        unique case (state_q)
            FETCH: begin
                imem_req = !reset && (occ < FULL) && !redirect && !mis_q;
                if (imem_req && imem_gnt) begin
                    tag_d   = pc_q;
                    pc_d    = pc_q + PC_STEP;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response colliding with a redirect belongs to the old path.
                if (imem_rvalid) begin
                    push    = !redirect;
                    state_d = FETCH;
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign pop    = instr_valid && instr_ready && !redirect;
    assign push_e = '{pc: tag_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .flush_i(redirect),
        .push_i (push),
        .pop_i  (pop),
        .data_i (push_e),
        .head_o (head_e),
        .empty_o(empty),
        .count_o(occ)
    );

    assign imem_addr   = pc_q;
    assign instr_valid = !empty;
    assign instr       = head_e.instr;
    assign instr_pc    = head_e.pc;
    assign op          = head_e.instr[OPCODE_W-1:0];
    assign misalign    = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cases plus random traffic
// checked against a queue-based reference model.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  op;
    logic        instr_ready = 1'b0;
    logic        misalign;

    fetch_unit #(
        .RESET_PC (RPC),
        .BUF_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .op         (op),
        .instr_ready(instr_ready),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: PC, one outstanding fetch, discard flag, buffer queue.
    logic [31:0] m_pc;
    logic [31:0] m_tag;
    bit          m_out;
    bit          m_disc;
    bit          m_mis;
    logic [63:0] m_buf[$];

    bit mem_busy  = 0;
    int mem_lat   = 0;
    int grant_cnt = 0;

    task automatic model_reset();
        m_pc   = RPC;
        m_tag  = '0;
        m_out  = 0;
        m_disc = 0;
        m_mis  = 0;
        m_buf.delete();
    endtask

    function automatic bit m_req(input logic rd);
        return !m_out && (m_buf.size() < DEPTH) && !rd && !m_mis;
    endfunction

    task automatic step(input logic rd, input logic [31:0] rpc,
                        input logic rdy, input logic g, input logic rv,
                        input logic [31:0] data);
        bit req_e;
        bit pop_e;
        bit push_e;
        redirect    = rd;
        redirect_pc = rpc;
        instr_ready = rdy;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = data;
        #1;
        req_e = m_req(rd);
        chk("req", imem_req, req_e);
        chk("addr", imem_addr, m_pc);
        chk("valid", instr_valid, m_buf.size() > 0);
        chk("misalign", misalign, m_mis);
        if (m_buf.size() > 0) begin
            chk("instr", instr, m_buf[0][31:0]);
            chk("instr_pc", instr_pc, m_buf[0][63:32]);
            chk("op", op, m_buf[0][6:0]);
        end
        if (imem_req && g) grant_cnt++;
        pop_e  = (m_buf.size() > 0) && rdy && !rd;
        push_e = m_out && rv && !m_disc && !rd;
        if (rd) begin
            m_buf.delete();
`ifdef FETCH_MISALIGN_CHK_EN
            m_pc  = rpc;
            m_mis = (rpc % 4) != 0;
`else
            m_pc  = rpc - (rpc % 4);
            m_mis = 0;
`endif
            if (m_out && !rv) m_disc = 1;
        end else begin
            if (pop_e) void'(m_buf.pop_front());
            if (push_e) m_buf.push_back({m_tag, data});
        end
        if (m_out && rv) begin
            m_out  = 0;
            m_disc = 0;
        end
        if (req_e && g) begin
            m_tag = m_pc;
            m_pc  = m_pc + 32'd4;
            m_out = 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_ipc", instr_pc, 0);
        chk("rst_op", op, 0);
        chk("rst_mis", misalign, 0);
        model_reset();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(3))
            0:       return r & 32'h0000_0FFC;
            1:       return 32'hFFFF_FFF8 | (r & 32'h4);
            2:       return r;
            default: return 32'h0000_0100;
        endcase
    endfunction

    task automatic run(input int n, input int rd_pct, input int rdy_pct,
                       input int lat_max);
        for (int i = 0; i < n; i++) begin
            logic rd, rdy, g, rv;
            logic [31:0] rpc;
            bit gr;
            rd  = $urandom_range(99) < rd_pct;
            rpc = pick_target();
            rdy = $urandom_range(99) < rdy_pct;
            g   = !mem_busy && ($urandom_range(3) != 0);
            rv  = mem_busy && (mem_lat == 0);
            gr  = m_req(rd) && g;
            step(rd, rpc, rdy, g, rv, $urandom);
            if (rv) mem_busy = 0;
            else if (mem_busy) mem_lat--;
            if (gr) begin
                mem_busy = 1;
                mem_lat  = $urandom_range(lat_max);
            end
        end
    endtask

    initial begin
        bit pend;
        int g0;
        do_reset();

        // First fetches, latency and opcode extraction
        step(0, 0, 0, 1, 0, 0);
        chk("a34_1", imem_addr, 32'h4);
        step(0, 0, 0, 1, 1, 32'h0000_0003);
        step(0, 0, 0, 1, 0, 0);
        chk("op34", op, 7'b0000011);
        chk("ipc34", instr_pc, 32'h0);
        step(0, 0, 1, 1, 1, 32'h0000_0013);
        chk("ipc34b", instr_pc, 32'h4);
        chk("a34_3", imem_addr, 32'h8);

        // Backpressure: only BUF_DEPTH fetches, then one per pop
        step(1, 0, 0, 0, 0, 0);
        grant_cnt = 0;
        pend = 0;
        for (int i = 0; i < 8; i++) begin
            g0 = grant_cnt;
            step(0, 0, 0, 1, pend, $urandom);
            pend = grant_cnt != g0;
        end
        chk("grants35", grant_cnt, 2);
        chk("req35", imem_req, 0);
        grant_cnt = 0;
        step(0, 0, 1, 0, 0, 0);
        pend = 0;
        for (int i = 0; i < 6; i++) begin
            g0 = grant_cnt;
            step(0, 0, 0, 1, pend, $urandom);
            pend = grant_cnt != g0;
        end
        chk("grants35b", grant_cnt, 1);

        // Redirect while waiting: stale response dropped
        step(1, 32'h40, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h100, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("v36", instr_valid, 0);
        chk("a36", imem_addr, 32'h100);
        step(0, 0, 0, 1, 0, 0);
        chk("v36b", instr_valid, 0);
        step(0, 0, 0, 0, 1, 32'h0000_0013);
        chk("v36c", instr_valid, 1);
        chk("ipc36", instr_pc, 32'h100);
        chk("i36", instr, 32'h0000_0013);

        // PC wrap
        step(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("a37", imem_addr, 32'h0);
        step(0, 0, 0, 0, 1, 32'h0000_0033);
        chk("ipc37", instr_pc, 32'hFFFF_FFFC);

        // Reset mid-WAIT, stray response afterwards
        step(0, 0, 0, 1, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("v38", instr_valid, 0);
        chk("a38", imem_addr, RPC);

`ifdef FETCH_MISALIGN_CHK_EN
        step(1, 32'h102, 0, 0, 0, 0);
        chk("mis39", misalign, 1);
        step(0, 0, 0, 1, 0, 0);
        chk("req39", imem_req, 0);
        step(1, 32'h200, 0, 0, 0, 0);
        chk("mis39b", misalign, 0);
        chk("a39", imem_addr, 32'h200);
        step(0, 0, 0, 1, 0, 0);
        chk("a39b", imem_addr, 32'h204);
        step(0, 0, 0, 0, 1, 32'h0000_0013);
`endif

        for (int k = 0; k < 5; k++) begin
            run(600, 8, 60, 3);
            do_reset();
        end
        run(400, 3, 90, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
